equalizer_mmio: RTL and testbench

Memory-mapped histogram/equalization peripheral on the pipelined ARM core's data bus, responding to the core's loads and stores (MemWrite, DataAdr, WriteData, ReadData) alongside data memory. The core pushes 8-bit pixel values by store. The block counts them into a 256-bin histogram, then on command runs a 256-cycle cumulative pass that fills a 256-entry equalization LUT. The core reads the LUT back by load.

---
 rtl/equalizer_mmio.sv | 153 +++++++++++++++
 tb/tb_equalizer_mmio.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/equalizer_mmio.sv
// equalizer_mmio: memory-mapped histogram and equalisation peripheral.
// The core stores 8-bit pixels into a 256-bin histogram. On command, a 256-cycle
// cumulative pass either clears the histogram or fills an equalisation LUT.
// All loads are combinational so they line up with the core's MEM stage.
module equalizer_mmio #(
    parameter logic [31:0] BASE        = 32'h0001_0000,
    parameter int          CNT_W       = 20,
    parameter int          LOG2_PIXELS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Hit
);

    // The product is wide enough to hold the largest running sum times 255.
    localparam int PROD_W = CNT_W + 9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_EQ
    } eqState_t;

    eqState_t           r_state;
    logic [7:0]         r_idx;
    logic [CNT_W:0]     r_acc;
    logic [CNT_W-1:0]   r_count;
    logic               r_done;
    logic               r_drop;
    logic [CNT_W-1:0]   r_hist [256];
    logic [7:0]         r_lut  [256];

    logic [11:0]        w_offset;
    logic [7:0]         w_word;
    logic [7:0]         w_bin;
    logic               w_busy;
    logic               w_ctrlWr;
    logic               w_pixelWr;
    logic               w_cmdValid;
    logic [CNT_W:0]     w_sum;
    logic [PROD_W-1:0]  w_product;
    logic [PROD_W-1:0]  w_scaled;
    logic [7:0]         w_lutVal;
    logic               w_unused;

    assign Hit        = (DataAdr[31:12] == BASE[31:12]);
    assign w_offset   = DataAdr[11:0];
    assign w_word     = DataAdr[9:2];
    assign w_bin      = WriteData[7:0];
    assign w_busy     = (r_state != S_IDLE);
    assign w_ctrlWr   = MemWrite && Hit && (w_offset == 12'h000);
    assign w_pixelWr  = MemWrite && Hit && (w_offset == 12'h008);
    assign w_cmdValid = WriteData[0] | WriteData[1];

    // Running cumulative sum and its scaled, clamped LUT value for the current bin.
    assign w_sum      = r_acc + {1'b0, r_hist[r_idx]};
    assign w_product  = PROD_W'(w_sum) * PROD_W'(255);
    assign w_scaled   = w_product >> LOG2_PIXELS;
    assign w_lutVal   = (w_scaled > PROD_W'(255)) ? 8'hFF : w_scaled[7:0];

    // Upper store-data bits carry no meaning for any register.
    assign w_unused   = &{1'b0, WriteData[31:8]};

    // Combinational load path: register window, histogram window, LUT window.
    always_comb begin
        ReadData = '0;
        if (Hit) begin
            if (w_offset[11:10] == 2'b01) begin
                ReadData = 32'(r_hist[w_word]);
            end else if (w_offset[11:10] == 2'b10) begin
                ReadData = 32'(r_lut[w_word]);
            end else begin
                case (w_offset)
                    12'h004: ReadData = {29'd0, r_drop, r_done, w_busy};
                    12'h00C: ReadData = 32'(r_count);
                    default: ReadData = '0;
                endcase
            end
        end
    end

    // Command FSM plus histogram, counter and LUT storage, all reset asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_acc   <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
            r_drop  <= 1'b0;
            for (int i = 0; i < 256; i++) begin
                r_hist[i] <= '0;
                r_lut[i]  <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pixelWr) begin
                        if (r_hist[w_bin] != '1) begin
                            r_hist[w_bin] <= r_hist[w_bin] + CNT_W'(1);
                        end
                        if (r_count != '1) begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                    if (w_ctrlWr && w_cmdValid) begin
                        r_idx  <= '0;
                        r_acc  <= '0;
                        r_done <= 1'b0;
                        r_drop <= 1'b0;
                        if (WriteData[0]) begin
                            r_state <= S_CLEAR;
                            r_count <= '0;
                        end else begin
                            r_state <= S_EQ;
                        end
                    end
                end
                S_CLEAR: begin
                    r_hist[r_idx] <= '0;
                    r_idx         <= r_idx + 8'd1;
                    if (w_pixelWr) begin
                        r_drop <= 1'b1;
                    end
                    if (r_idx == 8'hFF) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                S_EQ: begin
                    r_lut[r_idx] <= w_lutVal;
                    r_acc        <= w_sum;
                    r_idx        <= r_idx + 8'd1;
                    if (w_pixelWr) begin
                        r_drop <= 1'b1;
                    end
                    if (r_idx == 8'hFF) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_equalizer_mmio.sv
// tb_equalizer_mmio: directed bench for the histogram/equalisation peripheral.
// dutA uses the full 20-bit counters; dutB uses 4-bit counters so saturation shows up.
// Both share one bus and use a small normalisation shift so the LUT values are easy to hand-compute.
module tb_equalizer_mmio;

   localparam logic [31:0] A_CTRL   = 32'h0001_0000;
   localparam logic [31:0] A_STATUS = 32'h0001_0004;
   localparam logic [31:0] A_PIXEL  = 32'h0001_0008;
   localparam logic [31:0] A_COUNT  = 32'h0001_000C;
   localparam logic [31:0] A_HIST   = 32'h0001_0400;
   localparam logic [31:0] A_LUT    = 32'h0001_0800;

   logic        clk;
   logic        reset;
   logic        MemWrite;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic [31:0] readDataA;
   logic        hitA;
   logic [31:0] readDataB;
   logic        hitB;

   int errorCount = 0;
   int checkCount = 0;

   equalizer_mmio #(.BASE(32'h0001_0000), .CNT_W(20), .LOG2_PIXELS(2)) dutA (
      .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
      .WriteData(WriteData), .ReadData(readDataA), .Hit(hitA)
   );

   equalizer_mmio #(.BASE(32'h0001_0000), .CNT_W(4), .LOG2_PIXELS(2)) dutB (
      .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
      .WriteData(WriteData), .ReadData(readDataB), .Hit(hitB)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One store: presented at the falling edge, taken at the next rising edge.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      DataAdr   = addr;
      WriteData = data;
      MemWrite  = 1'b1;
      @(posedge clk);
      #1;
      MemWrite  = 1'b0;
   endtask

   task automatic readAt(input logic [31:0] addr);
      DataAdr = addr;
      #1;
   endtask

   task automatic waitIdle(input string name);
      int c;
      c = 0;
      readAt(A_STATUS);
      while (readDataA[0] === 1'b1 && c < 400) begin
         @(posedge clk);
         readAt(A_STATUS);
         c++;
      end
      checkCount++;
      if (readDataA[0] !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, readDataA[0], c);
      end
   endtask

   task automatic test_reset;
      logic [31:0] hitAddr [5];
      logic        hitExp  [5];
      hitAddr = '{32'h0000_FFFC, 32'h0001_0000, 32'h0001_0FFC, 32'h0001_1000, 32'h0000_0004};
      hitExp  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      reset = 1'b1; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      readAt(A_STATUS);
      checkCount++;
      if (readDataA !== 32'd0) begin errorCount++; $display("[TB] FAIL reset_status: got %h required %h", readDataA, 32'd0); end
      checkCount++;
      if (readDataB !== 32'd0) begin errorCount++; $display("[TB] FAIL reset_statusB: got %h required %h", readDataB, 32'd0); end
      readAt(A_COUNT);
      checkCount++;
      if (readDataA !== 32'd0) begin errorCount++; $display("[TB] FAIL reset_count: got %h required %h", readDataA, 32'd0); end
      readAt(A_HIST);
      checkCount++;
      if (readDataA !== 32'd0) begin errorCount++; $display("[TB] FAIL reset_hist0: got %h required %h", readDataA, 32'd0); end
      readAt(A_LUT + 32'h3FC);
      checkCount++;
      if (readDataA !== 32'd0) begin errorCount++; $display("[TB] FAIL reset_lut255: got %h required %h", readDataA, 32'd0); end
      for (int i = 0; i < 5; i++) begin
         readAt(hitAddr[i]);
         checkCount++;
         if (hitA !== hitExp[i]) begin
            errorCount++;
            $display("[TB] FAIL hit_%h: got %b required %b", hitAddr[i], hitA, hitExp[i]);
         end
      end
   endtask

   task automatic test_pixels;
      applyStimulus(A_PIXEL, 32'h0000_0005);
      applyStimulus(A_PIXEL, 32'h0000_0005);
      applyStimulus(A_PIXEL, 32'h0000_01FF);
      readAt(A_HIST + 32'h014);
      checkCount++;
      if (readDataA !== 32'd2) begin errorCount++; $display("[TB] FAIL hist5: got %h required %h", readDataA, 32'd2); end
      readAt(A_HIST + 32'h3FC);
      checkCount++;
      if (readDataA !== 32'd1) begin errorCount++; $display("[TB] FAIL hist255: got %h required %h", readDataA, 32'd1); end
      readAt(A_HIST + 32'h010);
      checkCount++;
      if (readDataA !== 32'd0) begin errorCount++; $display("[TB] FAIL hist4: got %h required %h", readDataA, 32'd0); end
      readAt(A_COUNT);
      checkCount++;
      if (readDataA !== 32'd3) begin errorCount++; $display("[TB] FAIL count3: got %h required %h", readDataA, 32'd3); end
      readAt(32'h0002_000C);
      checkCount++;
      if (readDataA !== 32'd0) begin errorCount++; $display("[TB] FAIL unselected_read: got %h required %h", readDataA, 32'd0); end
      readAt(32'h0001_0010);
      checkCount++;
      if (readDataA !== 32'd0) begin errorCount++; $display("[TB] FAIL unmapped_read: got %h required %h", readDataA, 32'd0); end
      applyStimulus(A_COUNT, 32'd99);
      readAt(A_COUNT);
      checkCount++;
      if (readDataA !== 32'd3) begin errorCount++; $display("[TB] FAIL count_readonly: got %h required %h", readDataA, 32'd3); end
   endtask

   task automatic test_equalize;
      int          n;
      logic [31:0] lutExp [4];
      lutExp = '{32'd127, 32'd191, 32'd191, 32'd255};
      applyStimulus(A_CTRL, 32'd1);
      waitIdle("pre_clear");
      applyStimulus(A_PIXEL, 32'd0);
      applyStimulus(A_PIXEL, 32'd0);
      applyStimulus(A_PIXEL, 32'd1);
      applyStimulus(A_PIXEL, 32'd3);
      readAt(A_COUNT);
      checkCount++;
      if (readDataA !== 32'd4) begin errorCount++; $display("[TB] FAIL eq_count: got %h required %h", readDataA, 32'd4); end
      applyStimulus(A_CTRL, 32'd2);
      n = 0;
      for (int c = 0; c < 400; c++) begin
         readAt(A_STATUS);
         if (readDataA[0] !== 1'b1) break;
         n++;
         @(posedge clk);
      end
      checkCount++;
      if (n !== 256) begin errorCount++; $display("[TB] FAIL eq_busy_cycles: got %0d required %0d", n, 256); end
      readAt(A_STATUS);
      checkCount++;
      if (readDataA !== 32'd2) begin errorCount++; $display("[TB] FAIL eq_status_done: got %h required %h", readDataA, 32'd2); end
      for (int i = 0; i < 4; i++) begin
         readAt(A_LUT + 32'(i * 4));
         checkCount++;
         if (readDataA !== lutExp[i]) begin
            errorCount++;
            $display("[TB] FAIL lut%0d: got %0d required %0d", i, readDataA, lutExp[i]);
         end
      end
      readAt(A_LUT + 32'h3FC);
      checkCount++;
      if (readDataA !== 32'd255) begin errorCount++; $display("[TB] FAIL lut255: got %0d required %0d", readDataA, 255); end
      readAt(A_LUT + 32'h004);
      checkCount++;
      if (readDataB !== 32'd191) begin errorCount++; $display("[TB] FAIL lut1_B: got %0d required %0d", readDataB, 191); end
   endtask

   task automatic test_clear_wins;
      applyStimulus(A_CTRL, 32'd3);
      readAt(A_STATUS);
      checkCount++;
      if (readDataA !== 32'd1) begin errorCount++; $display("[TB] FAIL clr_status_busy: got %h required %h", readDataA, 32'd1); end
      readAt(A_COUNT);
      checkCount++;
      if (readDataA !== 32'd0) begin errorCount++; $display("[TB] FAIL clr_count_entry: got %h required %h", readDataA, 32'd0); end
      waitIdle("clear");
      readAt(A_HIST);
      checkCount++;
      if (readDataA !== 32'd0) begin errorCount++; $display("[TB] FAIL clr_hist0: got %h required %h", readDataA, 32'd0); end
      readAt(A_HIST + 32'h00C);
      checkCount++;
      if (readDataA !== 32'd0) begin errorCount++; $display("[TB] FAIL clr_hist3: got %h required %h", readDataA, 32'd0); end
      readAt(A_LUT + 32'h00C);
      checkCount++;
      if (readDataA !== 32'd255) begin errorCount++; $display("[TB] FAIL clr_lut3_kept: got %0d required %0d", readDataA, 255); end
   endtask

   task automatic test_busy_drop;
      int n;
      applyStimulus(A_CTRL, 32'd2);
      repeat (10) @(posedge clk);
      applyStimulus(A_PIXEL, 32'd7);
      applyStimulus(A_CTRL, 32'd1);
      readAt(A_HIST + 32'h01C);
      checkCount++;
      if (readDataA !== 32'd0) begin errorCount++; $display("[TB] FAIL drop_hist7: got %h required %h", readDataA, 32'd0); end
      readAt(A_STATUS);
      checkCount++;
      if (readDataA !== 32'd5) begin errorCount++; $display("[TB] FAIL drop_status: got %h required %h", readDataA, 32'd5); end
      n = 0;
      for (int c = 0; c < 400; c++) begin
         readAt(A_STATUS);
         if (readDataA[0] !== 1'b1) break;
         n++;
         @(posedge clk);
      end
      checkCount++;
      if (n !== 244) begin errorCount++; $display("[TB] FAIL drop_remaining_busy: got %0d required %0d", n, 244); end
      readAt(A_STATUS);
      checkCount++;
      if (readDataA !== 32'd6) begin errorCount++; $display("[TB] FAIL drop_status_done: got %h required %h", readDataA, 32'd6); end
      readAt(A_LUT);
      checkCount++;
      if (readDataA !== 32'd0) begin errorCount++; $display("[TB] FAIL drop_lut0_recomputed: got %0d required %0d", readDataA, 0); end
      applyStimulus(A_CTRL, 32'd2);
      readAt(A_STATUS);
      checkCount++;
      if (readDataA !== 32'd1) begin errorCount++; $display("[TB] FAIL drop_cleared: got %h required %h", readDataA, 32'd1); end
      waitIdle("drop_eq");
   endtask

   task automatic test_saturation;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(A_PIXEL, 32'h0000_0009);
      end
      readAt(A_HIST + 32'h024);
      checkCount++;
      if (readDataB !== 32'd15) begin errorCount++; $display("[TB] FAIL sat_hist9_B: got %0d required %0d", readDataB, 15); end
      checkCount++;
      if (readDataA !== 32'd20) begin errorCount++; $display("[TB] FAIL hist9_A: got %0d required %0d", readDataA, 20); end
      readAt(A_COUNT);
      checkCount++;
      if (readDataB !== 32'd15) begin errorCount++; $display("[TB] FAIL sat_count_B: got %0d required %0d", readDataB, 15); end
      checkCount++;
      if (readDataA !== 32'd20) begin errorCount++; $display("[TB] FAIL count_A: got %0d required %0d", readDataA, 20); end
      readAt(A_HIST + 32'h020);
      checkCount++;
      if (readDataB !== 32'd0) begin errorCount++; $display("[TB] FAIL sat_hist8_B: got %0d required %0d", readDataB, 0); end
   endtask

   task automatic test_reset_mid_eq;
      int bad;
      applyStimulus(A_CTRL, 32'd2);
      repeat (100) @(posedge clk);
      #1;
      readAt(A_STATUS);
      checkCount++;
      if (readDataA !== 32'd1) begin errorCount++; $display("[TB] FAIL mid_eq_busy: got %h required %h", readDataA, 32'd1); end
      readAt(A_LUT + 32'h024);
      checkCount++;
      if (readDataA !== 32'd255) begin errorCount++; $display("[TB] FAIL mid_eq_lut9_A: got %0d required %0d", readDataA, 255); end
      checkCount++;
      if (readDataB !== 32'd255) begin errorCount++; $display("[TB] FAIL mid_eq_lut9_B: got %0d required %0d", readDataB, 255); end
      reset = 1'b1;
      readAt(A_STATUS);
      checkCount++;
      if (readDataA !== 32'd0 || readDataB !== 32'd0) begin
         errorCount++;
         $display("[TB] FAIL abort_status: got %h/%h required 0/0", readDataA, readDataB);
      end
      readAt(A_HIST + 32'h024);
      checkCount++;
      if (readDataA !== 32'd0) begin errorCount++; $display("[TB] FAIL abort_hist9: got %h required %h", readDataA, 32'd0); end
      readAt(A_COUNT);
      checkCount++;
      if (readDataA !== 32'd0) begin errorCount++; $display("[TB] FAIL abort_count: got %h required %h", readDataA, 32'd0); end
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         readAt(A_LUT + 32'(i * 4));
         if (readDataA !== 32'd0 || readDataB !== 32'd0) bad++;
      end
      checkCount++;
      if (bad !== 0) begin errorCount++; $display("[TB] FAIL abort_lut_scan: got %0d nonzero entries required %0d", bad, 0); end
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      readAt(A_STATUS);
      checkCount++;
      if (readDataA !== 32'd0) begin errorCount++; $display("[TB] FAIL post_reset_idle: got %h required %h", readDataA, 32'd0); end
   endtask

   // Runs every scenario in order, then reports.
   initial begin
      test_reset();
      test_pixels();
      test_equalize();
      test_clear_wins();
      test_busy_drop();
      test_saturation();
      test_reset_mid_eq();
      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

   // Hard stop in case the sequence above stalls.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
